// File: rtl/alu_ctrl_stage.sv
// alu_ctrl_stage: ID/EX control stage. Decodes a MIPS instruction into the
// execute-stage ALU control word and registers it behind a valid/ready
// handshake with stall and flush.
//
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   in_valid/in_ready/instr    upstream instruction handshake
//   flush          kill registered word (redirect)
//   out_valid/out_ready        downstream control word handshake
//   alu_fun, sign  ALU function code and signedness
//   src_a, src_b   operand selects (A: rs/shamt/zero, B: rt/imm32)
//   imm32          extended immediate (also carries shamt in bits [10:6])
//   wr_addr, reg_we            destination register and write enable
//   mem_rd, mem_wr, branch, illegal  instruction class flags
module alu_ctrl_stage #(
  parameter logic [5:0] NOP_FUN = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  alu_fun,
  output logic        sign,
  output logic [1:0]  src_a,
  output logic        src_b,
  output logic [31:0] imm32,
  output logic [4:0]  wr_addr,
  output logic        reg_we,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        branch,
  output logic        illegal
);

  localparam int unsigned FUN_W = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned XLEN  = 32;

  localparam logic [FUN_W-1:0] FUN_ADD = 6'b000000;
  localparam logic [FUN_W-1:0] FUN_SUB = 6'b000001;
  localparam logic [FUN_W-1:0] FUN_SLT = 6'b000011;
  localparam logic [FUN_W-1:0] FUN_AND = 6'b011000;
  localparam logic [FUN_W-1:0] FUN_OR  = 6'b011110;
  localparam logic [FUN_W-1:0] FUN_XOR = 6'b010110;
  localparam logic [FUN_W-1:0] FUN_NOR = 6'b010001;
  localparam logic [FUN_W-1:0] FUN_SLL = 6'b100000;
  localparam logic [FUN_W-1:0] FUN_SRL = 6'b100001;
  localparam logic [FUN_W-1:0] FUN_SRA = 6'b100011;
  localparam logic [FUN_W-1:0] FUN_EQ  = 6'b110011;
  localparam logic [FUN_W-1:0] FUN_NEQ = 6'b110001;
  localparam logic [FUN_W-1:0] FUN_LEZ = 6'b111101;
  localparam logic [FUN_W-1:0] FUN_LTZ = 6'b111011;
  localparam logic [FUN_W-1:0] FUN_GTZ = 6'b111111;

  localparam logic [1:0] SRC_A_RS    = 2'b00;
  localparam logic [1:0] SRC_A_SHAMT = 2'b01;
  localparam logic [1:0] SRC_A_ZERO  = 2'b10;

  typedef struct packed {
    logic [FUN_W-1:0] alu_fun;
    logic             sign;
    logic [1:0]       src_a;
    logic             src_b;
    logic [XLEN-1:0]  imm32;
    logic [REG_W-1:0] wr_addr;
    logic             reg_we;
    logic             mem_rd;
    logic             mem_wr;
    logic             branch;
    logic             illegal;
  } ctrl_t;

  logic [5:0]       op;
  logic [5:0]       funct;
  logic [REG_W-1:0] rt;
  logic [REG_W-1:0] rd;
  logic [15:0]      imm;
  logic             unused_rs;

  ctrl_t dec;
  logic  dec_ill;
  ctrl_t bubble;
  ctrl_t q;

  assign op        = instr[31:26];
  assign rt        = instr[20:16];
  assign rd        = instr[15:11];
  assign funct     = instr[5:0];
  assign imm       = instr[15:0];
  // rs is consumed by the register file, not by this stage.
  assign unused_rs = ^instr[25:21];

  // Bubble word driven after reset and flush.
  always_comb begin
    bubble         = '0;
    bubble.alu_fun = NOP_FUN;
  end

  // Instruction decode.
  always_comb begin
    dec         = '0;
    dec.alu_fun = NOP_FUN;
    // Sign-extended by default; for R-type this also forwards shamt in [10:6].
    dec.imm32   = {{16{imm[15]}}, imm};
    dec_ill     = 1'b0;

    case (op)
      6'h00: begin
        dec.wr_addr = rd;
        dec.reg_we  = 1'b1;
        case (funct)
          6'h20: begin dec.alu_fun = FUN_ADD; dec.sign = 1'b1; end
          6'h21: dec.alu_fun = FUN_ADD;
          6'h22: begin dec.alu_fun = FUN_SUB; dec.sign = 1'b1; end
          6'h23: dec.alu_fun = FUN_SUB;
          6'h24: dec.alu_fun = FUN_AND;
          6'h25: dec.alu_fun = FUN_OR;
          6'h26: dec.alu_fun = FUN_XOR;
          6'h27: dec.alu_fun = FUN_NOR;
          6'h2A: begin dec.alu_fun = FUN_SLT; dec.sign = 1'b1; end
          6'h2B: dec.alu_fun = FUN_SLT;
          6'h00: begin dec.alu_fun = FUN_SLL; dec.src_a = SRC_A_SHAMT; end
          6'h02: begin dec.alu_fun = FUN_SRL; dec.src_a = SRC_A_SHAMT; end
          6'h03: begin dec.alu_fun = FUN_SRA; dec.src_a = SRC_A_SHAMT; end
          6'h04: dec.alu_fun = FUN_SLL;
          6'h06: dec.alu_fun = FUN_SRL;
          6'h07: dec.alu_fun = FUN_SRA;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) begin
          dec.alu_fun = FUN_LTZ;
          dec.sign    = 1'b1;
          dec.branch  = 1'b1;
        end else begin
          dec_ill = 1'b1;
        end
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        dec.sign   = 1'b1;
        dec.branch = 1'b1;
        case (op)
          6'h04:   dec.alu_fun = FUN_EQ;
          6'h05:   dec.alu_fun = FUN_NEQ;
          6'h06:   dec.alu_fun = FUN_LEZ;
          default: dec.alu_fun = FUN_GTZ;
        endcase
      end
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B: begin
        dec.src_b   = 1'b1;
        dec.wr_addr = rt;
        dec.reg_we  = 1'b1;
        dec.alu_fun = FUN_ADD;
        case (op)
          6'h08: dec.sign = 1'b1;
          6'h0A: begin dec.alu_fun = FUN_SLT; dec.sign = 1'b1; end
          6'h0B: dec.alu_fun = FUN_SLT;
          6'h0C: begin dec.alu_fun = FUN_AND; dec.imm32 = {16'h0000, imm}; end
          6'h0D: begin dec.alu_fun = FUN_OR;  dec.imm32 = {16'h0000, imm}; end
          6'h0E: begin dec.alu_fun = FUN_XOR; dec.imm32 = {16'h0000, imm}; end
          6'h0F: begin dec.imm32 = {imm, 16'h0000}; dec.src_a = SRC_A_ZERO; end
          6'h23: dec.mem_rd = 1'b1;
          6'h2B: begin dec.mem_wr = 1'b1; dec.reg_we = 1'b0; end
          default: ;
        endcase
      end
      default: dec_ill = 1'b1;
    endcase

    // Undecodable words still flow down the pipe, but as harmless bubbles.
    if (dec_ill) begin
      dec         = '0;
      dec.alu_fun = NOP_FUN;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = ~out_valid | out_ready;

  // ID/EX register: flush beats load, load beats consume.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      q         <= bubble;
    end else if (flush) begin
      out_valid <= 1'b0;
      q         <= bubble;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign alu_fun = q.alu_fun;
  assign sign    = q.sign;
  assign src_a   = q.src_a;
  assign src_b   = q.src_b;
  assign imm32   = q.imm32;
  assign wr_addr = q.wr_addr;
  assign reg_we  = q.reg_we;
  assign mem_rd  = q.mem_rd;
  assign mem_wr  = q.mem_wr;
  assign branch  = q.branch;
  assign illegal = q.illegal;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// tb_alu_ctrl_stage: directed self-checking bench for alu_ctrl_stage with a
// table-driven reference decoder and a transaction-level pipeline model.
module tb_alu_ctrl_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  alu_fun;
  logic        sign;
  logic [1:0]  src_a;
  logic        src_b;
  logic [31:0] imm32;
  logic [4:0]  wr_addr;
  logic        reg_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        branch;
  logic        illegal;

  int n_chk  = 0;
  int n_fail = 0;

  alu_ctrl_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .alu_fun(alu_fun), .sign(sign), .src_a(src_a), .src_b(src_b),
    .imm32(imm32), .wr_addr(wr_addr), .reg_we(reg_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .branch(branch), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  fun;
    logic        sgn;
    logic [1:0]  sa;
    logic        sb;
    logic [31:0] imm;
    logic [4:0]  wr;
    logic        we;
    logic        mrd;
    logic        mwr;
    logic        br;
    logic        ill;
  } exp_t;

  // Reference tables indexed by funct (R-type) and opcode (I-type).
  logic [5:0] r_fun [64];
  bit         r_ok  [64];
  bit         r_sgn [64];
  bit         r_sh  [64];
  logic [5:0] i_fun [64];
  bit         i_ok  [64];
  bit         i_sgn [64];
  bit         i_zx  [64];

  task automatic set_r(input int f, input logic [5:0] fn, input bit s, input bit sh);
    r_ok[f] = 1; r_fun[f] = fn; r_sgn[f] = s; r_sh[f] = sh;
  endtask

  task automatic set_i(input int o, input logic [5:0] fn, input bit s, input bit zx);
    i_ok[o] = 1; i_fun[o] = fn; i_sgn[o] = s; i_zx[o] = zx;
  endtask

  task automatic init_tables();
    for (int k = 0; k < 64; k++) begin
      r_ok[k] = 0; r_fun[k] = 6'd0; r_sgn[k] = 0; r_sh[k] = 0;
      i_ok[k] = 0; i_fun[k] = 6'd0; i_sgn[k] = 0; i_zx[k] = 0;
    end
    set_r('h20, 6'b000000, 1, 0); set_r('h21, 6'b000000, 0, 0);
    set_r('h22, 6'b000001, 1, 0); set_r('h23, 6'b000001, 0, 0);
    set_r('h24, 6'b011000, 0, 0); set_r('h25, 6'b011110, 0, 0);
    set_r('h26, 6'b010110, 0, 0); set_r('h27, 6'b010001, 0, 0);
    set_r('h2A, 6'b000011, 1, 0); set_r('h2B, 6'b000011, 0, 0);
    set_r('h00, 6'b100000, 0, 1); set_r('h02, 6'b100001, 0, 1);
    set_r('h03, 6'b100011, 0, 1); set_r('h04, 6'b100000, 0, 0);
    set_r('h06, 6'b100001, 0, 0); set_r('h07, 6'b100011, 0, 0);
    set_i('h08, 6'b000000, 1, 0); set_i('h09, 6'b000000, 0, 0);
    set_i('h0A, 6'b000011, 1, 0); set_i('h0B, 6'b000011, 0, 0);
    set_i('h0C, 6'b011000, 0, 1); set_i('h0D, 6'b011110, 0, 1);
    set_i('h0E, 6'b010110, 0, 1); set_i('h0F, 6'b000000, 0, 0);
    set_i('h23, 6'b000000, 0, 0); set_i('h2B, 6'b000000, 0, 0);
  endtask

  function automatic exp_t bubble_word();
    exp_t e;
    e.fun = 6'b000000; e.sgn = 0; e.sa = 2'b00; e.sb = 0; e.imm = 32'h0;
    e.wr = 5'd0; e.we = 0; e.mrd = 0; e.mwr = 0; e.br = 0; e.ill = 0;
    return e;
  endfunction

  function automatic exp_t model_decode(input logic [31:0] x);
    exp_t e;
    int op, fn;
    e  = bubble_word();
    op = int'(x[31:26]);
    fn = int'(x[5:0]);
    if (op == 0 && r_ok[fn]) begin
      e.fun = r_fun[fn]; e.sgn = r_sgn[fn]; e.sa = r_sh[fn] ? 2'b01 : 2'b00;
      e.wr = x[15:11]; e.we = 1;
    end else if (op == 1 && x[20:16] == 5'd0) begin
      e.fun = 6'b111011; e.sgn = 1; e.br = 1;
    end else if (op >= 4 && op <= 7) begin
      e.sgn = 1; e.br = 1;
      case (op)
        4: e.fun = 6'b110011;
        5: e.fun = 6'b110001;
        6: e.fun = 6'b111101;
        default: e.fun = 6'b111111;
      endcase
    end else if (op != 0 && i_ok[op]) begin
      e.fun = i_fun[op]; e.sgn = i_sgn[op]; e.sb = 1; e.wr = x[20:16];
      e.we  = (op != 'h2B); e.mrd = (op == 'h23); e.mwr = (op == 'h2B);
      if (op == 'h0F) begin
        e.imm = {x[15:0], 16'h0000}; e.sa = 2'b10;
      end else if (i_zx[op]) begin
        e.imm = {16'h0000, x[15:0]};
      end else begin
        e.imm = {{16{x[15]}}, x[15:0]};
      end
    end else begin
      e.ill = 1;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level pipeline model.
  bit   m_valid;
  bit   m_bubble;
  exp_t m_exp;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid  <= 0;
      m_bubble <= 1;
    end else if (flush) begin
      m_valid  <= 0;
      m_bubble <= 1;
    end else if (in_valid && (!m_valid || out_ready)) begin
      m_valid  <= 1;
      m_bubble <= 0;
      m_exp    <= model_decode(instr);
    end else if (out_ready) begin
      m_valid  <= 0;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    exp_t b;
    b = bubble_word();
    check("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("alu_fun", 32'(alu_fun), 32'(m_exp.fun));
      check("reg_we", 32'(reg_we), 32'(m_exp.we));
      check("mem_rd", 32'(mem_rd), 32'(m_exp.mrd));
      check("mem_wr", 32'(mem_wr), 32'(m_exp.mwr));
      check("branch", 32'(branch), 32'(m_exp.br));
      check("illegal", 32'(illegal), 32'(m_exp.ill));
      check("sign", 32'(sign), 32'(m_exp.sgn));
      check("src_a", 32'(src_a), 32'(m_exp.sa));
      check("src_b", 32'(src_b), 32'(m_exp.sb));
      if (m_exp.sb) check("imm32", imm32, m_exp.imm);
      if (m_exp.we) check("wr_addr", 32'(wr_addr), 32'(m_exp.wr));
    end else if (m_bubble) begin
      check("bubble_alu_fun", 32'(alu_fun), 32'(b.fun));
      check("bubble_reg_we", 32'(reg_we), 32'(b.we));
      check("bubble_mem_rd", 32'(mem_rd), 32'(b.mrd));
      check("bubble_mem_wr", 32'(mem_wr), 32'(b.mwr));
      check("bubble_branch", 32'(branch), 32'(b.br));
      check("bubble_illegal", 32'(illegal), 32'(b.ill));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] x);
    in_valid = 1'b1;
    instr    = x;
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] vec [17];
  logic [31:0] b2b [4];
  logic [31:0] b2b_imm [4];
  logic [4:0]  b2b_wr [4];
  bit          acc;
  int          guard;

  initial begin
    init_tables();
    reset = 1'b0; in_valid = 1'b0; instr = 32'h0; flush = 1'b0; out_ready = 1'b1;

    // Model pins: hand-decoded words.
    begin
      exp_t e;
      e = model_decode(32'h3C071234);
      check("model_lui_imm", e.imm, 32'h12340000);
      e = model_decode(32'h000521C3);
      check("model_sra_fun", 32'(e.fun), 32'h23);
      e = model_decode(32'h04410003);
      check("model_regimm_ill", 32'(e.ill), 32'h1);
    end

    repeat (3) step();
    reset = 1'b1;
    step();
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_alu_fun", 32'(alu_fun), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);

    // addu $3,$1,$2
    send(32'h00221821);
    check("addu_fun", 32'(alu_fun), 32'h00);
    check("addu_sign", 32'(sign), 32'h0);
    check("addu_src_a", 32'(src_a), 32'h0);
    check("addu_src_b", 32'(src_b), 32'h0);
    check("addu_wr", 32'(wr_addr), 32'd3);
    check("addu_we", 32'(reg_we), 32'h1);

    // sra $4,$5,7 then andi
    send(32'h000521C3);
    check("sra_fun", 32'(alu_fun), 32'h23);
    check("sra_src_a", 32'(src_a), 32'h1);
    check("sra_wr", 32'(wr_addr), 32'd4);
    send(32'h30228001);
    check("andi_fun", 32'(alu_fun), 32'h18);
    check("andi_imm", imm32, 32'h00008001);
    check("andi_wr", 32'(wr_addr), 32'd2);
    check("andi_src_b", 32'(src_b), 32'h1);

    // bne
    send(32'h14220003);
    check("bne_fun", 32'(alu_fun), 32'h31);
    check("bne_sign", 32'(sign), 32'h1);
    check("bne_branch", 32'(branch), 32'h1);
    check("bne_we", 32'(reg_we), 32'h0);
    check("bne_src_b", 32'(src_b), 32'h0);

    // Stall with a new instruction presented, then flush.
    send(32'h00221821);
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h000521C3;
    for (int c = 0; c < 2; c++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'h1);
      check("stall_in_ready", 32'(in_ready), 32'h0);
      check("stall_fun", 32'(alu_fun), 32'h00);
      check("stall_wr", 32'(wr_addr), 32'd3);
      check("stall_src_a", 32'(src_a), 32'h0);
    end
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'h0);
    check("flush_in_ready", 32'(in_ready), 32'h1);
    check("flush_we", 32'(reg_we), 32'h0);
    out_ready = 1'b1;

    // Flush dominates a simultaneous load.
    in_valid = 1'b1; instr = 32'h00221821; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_vs_load_valid", 32'(out_valid), 32'h0);

    // Illegal opcode.
    send(32'hFC000000);
    check("ill_flag", 32'(illegal), 32'h1);
    check("ill_we", 32'(reg_we), 32'h0);
    check("ill_fun", 32'(alu_fun), 32'h00);
    check("ill_valid", 32'(out_valid), 32'h1);

    // Back-to-back: addi, lw, sw, lui.
    b2b[0] = 32'h20430005; b2b_imm[0] = 32'h00000005; b2b_wr[0] = 5'd3;
    b2b[1] = 32'h8C85FFFC; b2b_imm[1] = 32'hFFFFFFFC; b2b_wr[1] = 5'd5;
    b2b[2] = 32'hAC860010; b2b_imm[2] = 32'h00000010; b2b_wr[2] = 5'd6;
    b2b[3] = 32'h3C071234; b2b_imm[3] = 32'h12340000; b2b_wr[3] = 5'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      instr = b2b[k];
      step();
      check("b2b_valid", 32'(out_valid), 32'h1);
      check("b2b_imm", imm32, b2b_imm[k]);
      check("b2b_wr", 32'(wr_addr), 32'(b2b_wr[k]));
    end
    in_valid = 1'b0;
    step();

    // Mixed vectors under random backpressure; model checks each cycle.
    vec[0]  = 32'h0022182B; vec[1]  = 32'h00221827; vec[2]  = 32'h00A22006;
    vec[3]  = 32'h04400003; vec[4]  = 32'h04410003; vec[5]  = 32'h00000001;
    vec[6]  = 32'h3843FFFF; vec[7]  = 32'h2843FFF0; vec[8]  = 32'h18400002;
    vec[9]  = 32'h1C400002; vec[10] = 32'h10220002; vec[11] = 32'h00221820;
    vec[12] = 32'h00221822; vec[13] = 32'h2C43FFFF; vec[14] = 32'h34438000;
    vec[15] = 32'h70000000; vec[16] = 32'h00000000;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1;
      instr    = vec[i];
      guard    = 0;
      do begin
        out_ready = 1'($urandom_range(0, 1));
        #1;
        acc = in_ready;
        step();
        guard++;
      end while (!acc && guard < 50);
      if (!acc) check("accept_timeout", 32'(guard), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();

    // Asynchronous reset during a stall.
    send(32'h00221821);
    out_ready = 1'b0;
    step();
    check("pre_rst_valid", 32'(out_valid), 32'h1);
    #1 reset = 1'b0;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'h0);
    check("async_rst_fun", 32'(alu_fun), 32'h0);
    step();
    reset = 1'b1; out_ready = 1'b1;
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_stage.md
Name: alu_ctrl_stage

Overview:
Pipelined instruction-decode control stage. It produces the ALU control word (6-bit function code and signedness) plus operand selects for the execute-stage ALU. It converts a 32-bit MIPS instruction into the ALU function encoding and registers the result into the ID/EX boundary. The register has a valid/ready handshake, stall and flush. It is the producer side of the ALU control interface.

Parameters:
NOP_FUN, 6'b000000, alu_fun driven on bubbles/reset (ADD)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction word valid
in_ready  out  1  stage can accept instruction
instr  in  32  MIPS instruction
flush  in  1  kill registered contents (branch/jump redirect)
out_valid  out  1  registered control word valid
out_ready  in  1  execute stage accepts control word
alu_fun  out  6  ALU function code
sign  out  1  signed compare/overflow semantics
src_a  out  2  A operand: 00 rs, 01 shamt (zero-extended instr[10:6]), 10 zero
src_b  out  1  B operand: 0 rt, 1 imm32
imm32  out  32  extended immediate
wr_addr  out  5  destination register
reg_we  out  1  register write enable
mem_rd  out  1  load
mem_wr  out  1  store
branch  out  1  conditional branch; ALU compare result is the taken flag
illegal  out  1  undecodable instruction

Behaviour:
- Reset (reset=0, async): out_valid=0, alu_fun=NOP_FUN, all other outputs 0. Takes effect immediately regardless of clk.
- Handshake: in_ready = ~out_valid | out_ready (combinational).
- Load: on clk rise, if in_valid & in_ready, register the decoded word and set out_valid=1.
- Consume: if out_valid & out_ready and no load, set out_valid=0. Latency is 1 cycle.
- Stall: out_valid & ~out_ready holds every output bit-stable. instr is ignored.
- Flush: on clk rise, flush=1 forces out_valid=0, reg_we=mem_wr=mem_rd=branch=illegal=0 and alu_fun=NOP_FUN. Flush dominates a simultaneous load; the incoming instruction is dropped. in_ready is unaffected by flush.
- Control fields are don't-care while out_valid=0, except that the bubble values above are required after reset and after flush.
- Encodings:
  - ADD 000000, SUB 000001, SLT 000011.
  - AND 011000, OR 011110, XOR 010110, NOR 010001.
  - SLL 100000, SRL 100001, SRA 100011.
  - EQ 110011, NEQ 110001, LEZ 111101, LTZ 111011, GTZ 111111.
- R-type (op 0), by funct:
  - add 20 / addu 21 → ADD, sign 1/0.
  - sub 22 / subu 23 → SUB, sign 1/0.
  - and 24, or 25, xor 26, nor 27.
  - slt 2A → SLT, sign 1. sltu 2B → SLT, sign 0.
  - sll 00, srl 02, sra 03 → src_a=01.
  - sllv 04, srlv 06, srav 07 → src_a=00.
  - All R-type: wr_addr=rd, reg_we=1, src_b=0.
- I-type, common rules: src_b=1, wr_addr=rt, reg_we=1 unless noted.
  - addi 08 → ADD, sign 1. addiu 09 → ADD, sign 0.
  - slti 0A → SLT, sign 1. sltiu 0B → SLT, sign 0.
  - andi 0C → AND, ori 0D → OR, xori 0E → XOR; imm32 zero-extended.
  - lui 0F: imm32={imm,16'h0}, src_a=10, ADD.
  - lw 23: ADD, mem_rd=1.
  - sw 2B: ADD, mem_wr=1, reg_we=0.
  - All other I-type: imm32 sign-extended.
- Branches: src_b=0, sign=1, branch=1, reg_we=0.
  - beq 04 → EQ, bne 05 → NEQ.
  - blez 06 → LEZ, bgtz 07 → GTZ.
  - op 01 with rt=0 → LTZ.
- Illegal: any other opcode or funct, or op 01 with rt≠0 → illegal=1, reg_we=mem_rd=mem_wr=branch=0, alu_fun=NOP_FUN. Still handshaken as a valid word.
- Writes to register 0 are passed through unchanged; the register file ignores them.

Test Plan:
- Reset low, then high, no input → out_valid=0, alu_fun=000000, in_ready=1. Assert reset mid-stall with out_valid=1 → out_valid=0 immediately, without a clock edge.
- instr=0x00221821 (addu $3,$1,$2), out_ready=1 → next cycle alu_fun=000000, sign=0, src_a=00, src_b=0, wr_addr=3, reg_we=1.
- instr=0x000521C3 (sra $4,$5,7) → alu_fun=100011, src_a=01, wr_addr=4. Then 0x30228001 (andi) → alu_fun=011000, imm32=0x00008001, wr_addr=2, src_b=1.
- instr=0x14220003 (bne) → alu_fun=110001, sign=1, branch=1, reg_we=0, src_b=0.
- Load 0x00221821, then out_ready=0 for 3 cycles with new instr applied → outputs unchanged, in_ready=0. Assert flush on cycle 2 → out_valid=0 next cycle, in_ready=1.
- instr=0xFC000000 (op 3F) → illegal=1, reg_we=0, alu_fun=000000, out_valid=1. Back-to-back 4 instructions with out_ready=1 → one output per cycle, no bubbles.
